// File: rtl/seg_scan_ctrl.sv
// Scan controller for NUM_DIGITS common-anode digits sharing one registered BCD->7-seg decoder.
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always lit).
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int IDX_W       = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  output logic                      load_ack,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic [IDX_W-1:0]          digit_idx,
  output logic                      frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [FW-1:0]   active;
  logic [FW-1:0]   pending;
  logic            pending_valid;

  // Load handshake: load is a one-cycle strobe with no ready; the last strobe before a
  // frame boundary wins, and load_ack pulses once in the cycle pending becomes active.
  logic            tick;
  logic            blank_done;
  logic            last_digit;
  logic            wrap;
  logic            promote;
  logic            lit_now;
  logic [IDX_W-1:0] next_idx;
  logic [FW-1:0]   active_next;

  function automatic logic [3:0] nibble_at(input logic [FW-1:0] frame,
                                           input logic [IDX_W-1:0] idx);
    logic [3:0] nib;
    nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) nib = frame[4*i +: 4];
    end
    return nib;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] an;
    an = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) an[i] = 1'b0;
    end
    return an;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it is digit 0 or any nibble at or above it is non-zero.
  function automatic logic lz_lit(input logic [FW-1:0] frame,
                                  input logic [IDX_W-1:0] idx);
    logic any_nz;
    any_nz = (idx == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (frame[4*i +: 4] != 4'd0)) any_nz = 1'b1;
    end
    return any_nz;
  endfunction

  assign lit_now = lz_lit(active, digit_idx);
`else
  assign lit_now = 1'b1;
`endif

  // The prescaler spans the whole slot, so its first two counts are the blank window.
  assign tick        = (presc == PW'(REFRESH_DIV - 1));
  assign blank_done  = (presc == PW'(1));
  assign last_digit  = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign next_idx    = last_digit ? '0 : digit_idx + IDX_W'(1);
  assign wrap        = (state == S_DRIVE) && enable && tick && last_digit;
  assign promote     = pending_valid && ((state == S_IDLE) || wrap);
  assign active_next = promote ? pending : active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      presc         <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      load_ack      <= 1'b0;
      frame_start   <= 1'b0;
      bcd_out       <= 4'd0;
      an_out        <= '1;
      digit_idx     <= '0;
    end else begin
      load_ack    <= 1'b0;
      frame_start <= 1'b0;

      if (promote) begin
        active        <= pending;
        pending_valid <= 1'b0;
        load_ack      <= 1'b1;
      end
      // Placed after promotion so a coincident load survives as the new pending frame.
      if (load) begin
        pending       <= digits_in;
        pending_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          presc     <= '0;
          an_out    <= '1;
          digit_idx <= '0;
          if (enable) begin
            state   <= S_BLANK;
            bcd_out <= nibble_at(active_next, '0);
          end
        end

        S_BLANK: begin
          if (!enable) begin
            state     <= S_IDLE;
            presc     <= '0;
            an_out    <= '1;
            digit_idx <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (blank_done) begin
              state  <= S_DRIVE;
              an_out <= lit_now ? onehot_low(digit_idx) : '1;
            end
          end
        end

        S_DRIVE: begin
          if (!enable) begin
            state     <= S_IDLE;
            presc     <= '0;
            an_out    <= '1;
            digit_idx <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              state       <= S_BLANK;
              an_out      <= '1;
              digit_idx   <= next_idx;
              bcd_out     <= nibble_at(active_next, next_idx);
              frame_start <= last_digit;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          presc     <= '0;
          an_out    <= '1;
          digit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random traffic, checked every cycle
// against a slot-arithmetic reference model (cycle count since scan start -> digit/phase).
module tb_seg_scan_ctrl;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load;
  logic [15:0]   digits_in;
  logic          load_ack;
  logic [3:0]    bcd_out;
  logic [N-1:0]  an_out;
  logic [IW-1:0] digit_idx;
  logic          frame_start;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .digits_in   (digits_in),
    .load_ack    (load_ack),
    .bcd_out     (bcd_out),
    .an_out      (an_out),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: scanning flag, cycles since scan start, displayed frame
  bit          m_scan = 1'b0;
  int          m_cyc  = 0;
  logic [15:0] m_act  = '0;
  logic        m_ack  = 1'b0;
  logic        m_fs   = 1'b0;
  logic [3:0]  m_bcd  = '0;
  logic [15:0] exp_q[$];   // pending frame waiting for the next frame boundary

  function automatic int cur_digit();
    return (m_cyc / DIV) % N;
  endfunction

  function automatic bit digit_lit(int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d == 0) || ((m_act >> (4 * d)) != 16'd0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [N-1:0] exp_an();
    int d;
    if (!m_scan) return '1;
    d = cur_digit();
    if ((m_cyc % DIV) < 2) return '1;
    if (!digit_lit(d)) return '1;
    return ~(N'(1) << d);
  endfunction

  task automatic model_step();
    bit promote;
    promote = 1'b0;
    if (rst) begin
      m_scan = 1'b0; m_cyc = 0; m_act = '0; m_ack = 1'b0; m_fs = 1'b0; m_bcd = '0;
      exp_q.delete();
      return;
    end
    m_ack = 1'b0;
    m_fs  = 1'b0;
    if (!m_scan) begin
      promote = (exp_q.size() != 0);
      if (enable) begin m_scan = 1'b1; m_cyc = 0; end
    end else if (!enable) begin
      m_scan = 1'b0; m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_cyc % (DIV * N) == 0) begin
        m_fs = 1'b1;
        promote = (exp_q.size() != 0);
      end
    end
    if (promote) begin
      m_act = exp_q.pop_front();
      m_ack = 1'b1;
    end
    if (load) begin
      exp_q.delete();
      exp_q.push_back(digits_in);
    end
    if (m_scan) m_bcd = m_act[4 * cur_digit() +: 4];
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("an_out",      an_out,      exp_an());
    chk("digit_idx",   digit_idx,   m_scan ? cur_digit() : 0);
    chk("bcd_out",     bcd_out,     m_bcd);
    chk("load_ack",    load_ack,    m_ack);
    chk("frame_start", frame_start, m_fs);
    chk("an_one_hot",  $countones(~an_out) <= 1, 1);
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_slot(int d, int pos);
    int guard;
    guard = 0;
    while (!(m_scan && cur_digit() == d && (m_cyc % DIV) == pos) && guard < 200) begin
      tick();
      guard++;
    end
    chk("wait_slot_bound", guard < 200, 1);
  endtask

  task automatic do_load(logic [15:0] v);
    load = 1'b1;
    digits_in = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0;
    run(3);
    rst = 1'b0;
    run(40);

    // load in idle, then scan 1234
    enable = 1'b0;
    tick();
    do_load(16'h1234);
    run(3);
    enable = 1'b1;
    run(2 * DIV * N);

    // mid-frame load during digit 1
    run_until_slot(1, 3);
    do_load(16'h5678);
    run(70);

    // two loads inside one frame, last wins
    run_until_slot(0, 4);
    do_load(16'h1111);
    run(5);
    do_load(16'h2222);
    run(70);

    // enable dropped during drive of digit 2, then re-enabled
    run_until_slot(2, 4);
    enable = 1'b0;
    tick();
    run(3);
    enable = 1'b1;
    run(40);

    // leading-zero pattern and nibbles above 9
    do_load(16'h0070);
    run(70);
    do_load(16'hF0AB);
    run(70);

    // load coincident with promotion
    do_load(16'h4321);
    run_until_slot(N - 1, DIV - 1);
    do_load(16'h9ABC);
    run(70);

    // reset mid-scan
    run_until_slot(2, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(40);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      enable    = ($urandom_range(0, 99) < 97);
      load      = ($urandom_range(0, 29) == 0);
      digits_in = 16'($urandom);
      rst       = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
    run(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
